// File: rtl/my_driver_bfm_pkg.sv
// Shared types and defaults for the my_driver_bfm valid/ready beat driver.
package my_driver_bfm_pkg;

  typedef enum logic {
    SEND = 1'b0,
    GAP  = 1'b1
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int COUNT_W        = 8;
  localparam int GAP_CNT_W      = 4;

  // The gap counter counts down to zero, so it is loaded with one less than the gap length.
  function automatic logic [GAP_CNT_W-1:0] gap_load(input int cycles);
    return GAP_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/my_driver_bfm_fifo.sv
// Ordered beat storage with wrapping read/write pointers and an occupancy level.
module my_driver_bfm_fifo
  import my_driver_bfm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // An empty FIFO presents zero so stale storage never leaks out after reset.
  assign rdata = (level != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/my_driver_bfm.sv
// Valid/ready beat driver: FIFO-buffered beats with a pop counter.
// Define MY_DRIVER_BFM_GAP_EN to insert GAP_CYCLES idle cycles after every output beat.
module my_driver_bfm
  import my_driver_bfm_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [COUNT_W-1:0]     count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_param_check
    $error("my_driver_bfm: illegal DEPTH or GAP_CYCLES");
  end

  logic push;
  logic pop;

  // No pop bypass: a full FIFO refuses input even if it is being drained this cycle.
  assign in_ready = !rst && (level < LVL_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  my_driver_bfm_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (out_data),
    .level (level)
  );

`ifdef MY_DRIVER_BFM_GAP_EN
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = gap_load(GAP_CYCLES);

  state_t                 state;
  state_t                 state_nx;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEND;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  // Beats pushed during GAP stay queued; they appear once the FSM is back in SEND.
  always_comb begin
    state_nx   = state;
    gap_cnt_nx = gap_cnt;
    out_valid  = 1'b0;
    case (state)
      SEND: begin
        out_valid = (level != '0);
        if (out_valid && out_ready) begin
          state_nx   = GAP;
          gap_cnt_nx = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nx = SEND;
        end else begin
          gap_cnt_nx = gap_cnt - GAP_CNT_W'(1);
        end
      end
      default: state_nx = SEND;
    endcase
  end
`else
  assign out_valid = (level != '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (pop) begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_my_driver_bfm.sv
// Randomized and directed bench for my_driver_bfm against a queue-based behavioural model.
module tb_my_driver_bfm;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 2;
`ifdef MY_DRIVER_BFM_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        count;
  logic [2:0]        level;

  int checks = 0;
  int errors = 0;

  my_driver_bfm #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of stored beats, a pop tally and the idle cycles still owed.
  logic [DATA_W-1:0] q[$];
  logic [7:0]        m_count = '0;
  int                m_gap = 0;
  int                model_pops = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_count = '0;
      m_gap   = 0;
    end else begin : model_step
      bit do_push;
      bit do_pop;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && (m_gap == 0) && out_ready;
      if (m_gap > 0) m_gap--;
      if (do_pop) begin
        void'(q.pop_front());
        m_count = m_count + 8'd1;
        model_pops++;
        if (GAP_EN) m_gap = GAP_CYCLES;
      end
      if (do_push) q.push_back(in_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, (!rst && q.size() < DEPTH)});
    chk("cmp_level", {29'd0, level}, q.size());
    chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0 && m_gap == 0)});
    chk("cmp_count", {24'd0, count}, {24'd0, m_count});
    if (q.size() != 0) chk("cmp_out_data", {24'd0, out_data}, {24'd0, q[0]});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int p0;
    // Reset held for 3 cycles.
    repeat (3) cyc();
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Ordered transfer of A5 then 3C.
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    cyc();
    in_data = 8'h3C;
    chk("ord_first_valid", {31'd0, out_valid}, 32'd1);
    chk("ord_first_data", {24'd0, out_data}, 32'hA5);
    cyc();
    in_valid = 1'b0;
`ifdef MY_DRIVER_BFM_GAP_EN
    chk("gap_idle_1", {31'd0, out_valid}, 32'd0);
    cyc();
    chk("gap_idle_2", {31'd0, out_valid}, 32'd0);
    cyc();
`endif
    chk("ord_second_valid", {31'd0, out_valid}, 32'd1);
    chk("ord_second_data", {24'd0, out_data}, 32'h3C);
    cyc();
    out_ready = 1'b0;
    chk("ord_count", {24'd0, count}, 32'd2);
    chk("ord_level", {29'd0, level}, 32'd0);

    // Full condition: five beats offered into a four-entry FIFO with no drain.
    pulse_rst();
    cyc();
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      cyc();
    end
    in_data = 8'd5;
    chk("full_level", {29'd0, level}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) cyc();
    chk("full_pending_level", {29'd0, level}, 32'd4);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("full_after_pop_level", {29'd0, level}, 32'd3);
    chk("full_after_pop_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("full_fifth_level", {29'd0, level}, 32'd4);
    chk("full_head", {24'd0, out_data}, 32'd2);

    // Backpressure with 11 at the head.
    pulse_rst();
    cyc();
    in_valid = 1'b1; in_data = 8'h11;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {24'd0, out_data}, 32'h11);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("bp_count", {24'd0, count}, 32'd1);
    chk("bp_level", {29'd0, level}, 32'd0);

    // Count wrap after 256 pops.
    pulse_rst();
    cyc();
    p0 = model_pops;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3000 && (model_pops - p0) < 256; i++) begin
      in_data = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_pops", model_pops - p0, 32'd256);
    chk("wrap_count", {24'd0, count}, 32'd0);

    // Asynchronous reset with three beats stored.
    pulse_rst();
    cyc();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    chk("mid_level_before", {29'd0, level}, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("mid_level_now", {29'd0, level}, 32'd0);
    chk("mid_valid_now", {31'd0, out_valid}, 32'd0);
    chk("mid_in_ready_now", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    cyc();
    in_valid = 1'b1; in_data = 8'h5A;
    cyc();
    in_valid = 1'b0;
    chk("mid_after_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_after_data", {24'd0, out_data}, 32'h5A);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("mid_after_count", {24'd0, count}, 32'd1);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      if (i == 700) pulse_rst();
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_driver_bfm.md
MY_DRIVER_BFM -- requirements
Module: my_driver_bfm

Interface
REQ-001 Parameter DATA_W, default 8, width of the data path.
REQ-002 Parameter DEPTH, default 4, FIFO entries; must be a power of two, at least 2.
REQ-003 Parameter GAP_CYCLES, default 2, idle cycles inserted after each output beat when the gap feature is compiled in; range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers a beat.
REQ-007 in_ready  output  1  block accepts a beat; a push occurs when in_valid and in_ready are both high.
REQ-008 in_data  input  DATA_W  upstream beat payload.
REQ-009 out_valid  output  1  block drives a beat.
REQ-010 out_ready  input  1  downstream accepts; a pop occurs when out_valid and out_ready are both high.
REQ-011 out_data  output  DATA_W  driven beat payload.
REQ-012 count  output  8  number of popped beats, modulo 256.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 The FIFO shall store pushed beats in order; out_data shall always equal the oldest stored entry.
REQ-015 in_ready shall be high exactly when level < DEPTH and rst is low; there is no same-cycle pop bypass when the FIFO is full.
REQ-016 A beat pushed in cycle N shall first be visible on out_valid and out_data in cycle N+1; there is no combinational in-to-out path.
REQ-017 While out_valid is high and out_ready is low, out_valid and out_data shall hold stable.
REQ-018 Simultaneous push and pop shall leave level unchanged and preserve ordering; a push with no pop increments level, and a pop with no push decrements level.
REQ-019 count shall increment by 1 on each pop and wrap from 255 to 0.
REQ-020 Control FSM states:
- SEND: out_valid = (level != 0).
- GAP: out_valid = 0, used only when the gap feature is compiled in.
REQ-021 The read and write pointers shall wrap modulo DEPTH; level shall saturate neither high nor low, because pushes while full and pops while empty are impossible by the handshake.
REQ-022 A push into an empty FIFO occurring in the same cycle as a gap shall be held until the gap expires.

Reset
REQ-023 While rst is high: level = 0, count = 0, out_valid = 0, out_data = 0, in_ready = 0, FSM = SEND, and the gap counter = 0.
REQ-024 Assertion of rst mid-transfer shall discard all stored beats immediately, without waiting for a clock edge.
REQ-025 On the first edge after rst deasserts, in_ready shall be 1.

Configuration
REQ-026 Macro MY_DRIVER_BFM_GAP_EN, when defined:
- After every pop, the FSM enters GAP for exactly GAP_CYCLES cycles, during which out_valid = 0.
- The FSM then returns to SEND.
- Pushes continue normally during GAP.
REQ-027 When MY_DRIVER_BFM_GAP_EN is undefined:
- The GAP state and the gap counter are absent.
- Back-to-back pops every cycle are possible.

Structure
REQ-028 Package my_driver_bfm_pkg shall hold:
- the FSM state enum (SEND, GAP);
- default constants for DATA_W, DEPTH and GAP_CYCLES;
- the count width constant (8).
REQ-029 Storage and pointers shall be in one sub-module, my_driver_bfm_fifo.
- The top level contains the FSM, the gap counter and count.

Verification
REQ-030 Reset check: with rst held high for 3 cycles, level=0, count=0, out_valid=0 and in_ready=0; one cycle after release, in_ready=1.
REQ-031 Ordered transfer: push 8'hA5 then 8'h3C with out_ready=1 and gap off. Required response:
- out_data is 8'hA5 then 8'h3C on consecutive cycles, starting one cycle after the first push;
- count ends at 2.
REQ-032 Full condition: with DEPTH=4 and out_ready=0, push 5 beats. Required response:
- in_ready drops after the 4th push and level=4;
- the 5th beat stays pending until one pop occurs.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles with 8'h11 at the head; out_valid and out_data stay constant, then one pop occurs when out_ready rises.
REQ-034 Wrap and gap:
- Perform 256 pops; count returns to 0.
- With MY_DRIVER_BFM_GAP_EN defined and GAP_CYCLES=2, out_valid is low for exactly 2 cycles between consecutive beats.
REQ-035 Reset mid-operation: with level=3, pulse rst asynchronously; level and out_valid go to 0 immediately, and subsequent pushes are delivered normally.
